// File: rtl/ofm_rd_addr_controller_pkg.sv
// Shared definitions for the OFM address controllers: FSM encoding and
// geometry helpers for the channel-planar OFM layout.
package ofm_rd_addr_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_TILE_END = 2'd2,
    ST_DONE     = 2'd3
  } ofm_rd_state_e;

  function automatic int unsigned plane_words(input int unsigned ofm_size);
    return ofm_size * ofm_size;
  endfunction

  function automatic int unsigned tile_count(input int unsigned ofm_size,
                                             input int unsigned systolic_size);
    return plane_words(ofm_size) / systolic_size;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofm_rd_addr_controller.sv
// Reads back an OFM block of SYSTOLIC_SIZE channel planes, one address per
// channel per tile, over a valid/ready handshake with registered outputs.
module ofm_rd_addr_controller
  import ofm_rd_addr_controller_pkg::*;
#(
  parameter int unsigned           SYSTOLIC_SIZE = 16,
  parameter int unsigned           OFM_SIZE      = 32,
  parameter int unsigned           ADDR_WIDTH    = 22,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic                  tile_last,
  output logic                  frame_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PLANE  = plane_words(OFM_SIZE);
  localparam int unsigned TILES  = tile_count(OFM_SIZE, SYSTOLIC_SIZE);
  localparam int unsigned CH_W   = cnt_width(SYSTOLIC_SIZE);
  localparam int unsigned TILE_W = cnt_width(TILES);

  localparam logic [CH_W-1:0]       CH_LAST    = CH_W'(SYSTOLIC_SIZE - 1);
  localparam logic [TILE_W-1:0]     TILE_LAST  = TILE_W'(TILES - 1);
  localparam logic [ADDR_WIDTH-1:0] PLANE_INC  = ADDR_WIDTH'(PLANE);
  localparam logic [ADDR_WIDTH-1:0] TILE_INC   = ADDR_WIDTH'(SYSTOLIC_SIZE);
  localparam logic                  SINGLE_CH  = (SYSTOLIC_SIZE == 1);
  localparam logic                  SINGLE_TL  = (TILES == 1);

  ofm_rd_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [TILE_W-1:0]       tile_q, tile_d;
  logic                    valid_q, valid_d;
  logic                    tlast_q, tlast_d;
  logic                    flast_q, flast_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [CH_W-1:0]         ch_nxt_c;
  logic [TILE_W-1:0]       tile_nxt_c;
  logic [ADDR_WIDTH-1:0]   base_nxt_c;

  assign ch_nxt_c   = ch_q + CH_W'(1);
  assign tile_nxt_c = tile_q + TILE_W'(1);
  assign base_nxt_c = base_q + TILE_INC;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= START_ADDR;
      addr_q  <= '0;
      ch_q    <= '0;
      tile_q  <= '0;
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
      flast_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      ch_q    <= ch_d;
      tile_q  <= tile_d;
      valid_q <= valid_d;
      tlast_q <= tlast_d;
      flast_q <= flast_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state; flags are computed for the address being loaded, so they
  // register alongside it.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    ch_d    = ch_q;
    tile_d  = tile_q;
    valid_d = valid_q;
    tlast_d = tlast_q;
    flast_d = flast_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d = ST_ISSUE;
          base_d  = START_ADDR;
          addr_d  = START_ADDR;
          ch_d    = '0;
          tile_d  = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          tlast_d = SINGLE_CH;
          flast_d = SINGLE_CH && SINGLE_TL;
        end
      end

      ST_ISSUE: begin
        if (rd_ready) begin
          if (ch_q != CH_LAST) begin
            ch_d    = ch_nxt_c;
            addr_d  = addr_q + PLANE_INC;
            tlast_d = (ch_nxt_c == CH_LAST);
            flast_d = (ch_nxt_c == CH_LAST) && (tile_q == TILE_LAST);
          end else begin
            valid_d = 1'b0;
            tlast_d = 1'b0;
            flast_d = 1'b0;
            if (tile_q != TILE_LAST) begin
              state_d = ST_TILE_END;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end

      ST_TILE_END: begin
        state_d = ST_ISSUE;
        base_d  = base_nxt_c;
        addr_d  = base_nxt_c;
        tile_d  = tile_nxt_c;
        ch_d    = '0;
        valid_d = 1'b1;
        tlast_d = SINGLE_CH;
        flast_d = SINGLE_CH && (tile_nxt_c == TILE_LAST);
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_addr    = addr_q;
  assign rd_valid   = valid_q;
  assign tile_last  = tlast_q;
  assign frame_last = flast_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ofm_rd_addr_controller.sv
// Scoreboard bench for the OFM read address controller across three
// configurations: defaults, a small 4x4 geometry and a wrapping start address.
module tb_ofm_rd_addr_controller;

  typedef struct {
    logic [21:0] addr;
    logic        tl;
    logic        fl;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_s [3];
  logic        ready_s [3];
  logic [21:0] addr_s  [3];
  logic        valid_s [3];
  logic        tl_s    [3];
  logic        fl_s    [3];
  logic        busy_s  [3];
  logic        done_s  [3];

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [21:0] WRAP_START = 22'd4194284;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ofm_rd_addr_controller dut_def (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .rd_ready(ready_s[0]),
    .rd_addr(addr_s[0]), .rd_valid(valid_s[0]), .tile_last(tl_s[0]),
    .frame_last(fl_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  ofm_rd_addr_controller #(
    .SYSTOLIC_SIZE(4), .OFM_SIZE(4), .ADDR_WIDTH(22), .START_ADDR(22'd100)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .rd_ready(ready_s[1]),
    .rd_addr(addr_s[1]), .rd_valid(valid_s[1]), .tile_last(tl_s[1]),
    .frame_last(fl_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  ofm_rd_addr_controller #(
    .START_ADDR(WRAP_START)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .rd_ready(ready_s[2]),
    .rd_addr(addr_s[2]), .rd_valid(valid_s[2]), .tile_last(tl_s[2]),
    .frame_last(fl_s[2]), .busy(busy_s[2]), .done(done_s[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input int idx, input string tag);
    check({tag, "_addr"},  64'(addr_s[idx]),  64'd0);
    check({tag, "_valid"}, 64'(valid_s[idx]), 64'd0);
    check({tag, "_tl"},    64'(tl_s[idx]),    64'd0);
    check({tag, "_fl"},    64'(fl_s[idx]),    64'd0);
    check({tag, "_busy"},  64'(busy_s[idx]),  64'd0);
    check({tag, "_done"},  64'(done_s[idx]),  64'd0);
  endtask

  // One frame on instance idx; bp = percent of cycles with rd_ready high.
  task automatic run_frame(input int idx, input int ss, input int plane, input int tiles,
                           input logic [21:0] sa, input int bp, input int exp_done,
                           input int abort_cyc, input bit extra_starts);
    int   cyc;
    bit   got_done;
    logic rdy;
    logic v;
    exp_q.delete();
    for (int t = 0; t < tiles; t++) begin
      for (int c = 0; c < ss; c++) begin
        exp_t e;
        longint unsigned a;
        a = longint'(sa) + longint'(t * ss) + longint'(c) * longint'(plane);
        e.addr = a[21:0];
        e.tl   = (c == ss - 1);
        e.fl   = (c == ss - 1) && (t == tiles - 1);
        exp_q.push_back(e);
      end
    end

    @(negedge clk);
    start_s[idx] = 1'b1;
    ready_s[idx] = 1'b1;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start_s[idx] = extra_starts && (cyc == 5 || cyc == 500);
      check("busy_during_frame", 64'(busy_s[idx]), 64'd1);
      v = valid_s[idx];
      if (v) begin
        if (exp_q.size() == 0) begin
          check("extra_address", 64'(v), 64'd0);
        end else begin
          check("rd_addr",    64'(addr_s[idx]), 64'(exp_q[0].addr));
          check("tile_last",  64'(tl_s[idx]),   64'(exp_q[0].tl));
          check("frame_last", 64'(fl_s[idx]),   64'(exp_q[0].fl));
        end
      end
      rdy = (bp >= 100) ? 1'b1 : ($urandom_range(99) < 32'(bp));
      ready_s[idx] = rdy;
      if (v && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (done_s[idx]) begin
        got_done = 1'b1;
        check("done_valid_low", 64'(v), 64'd0);
        check("addresses_left_at_done", 64'(exp_q.size()), 64'd0);
        if (exp_done > 0) check("done_cycle", 64'(cyc), 64'(exp_done));
      end
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs(idx, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        start_s[idx] = 1'b0;
        exp_q.delete();
        return;
      end
    end
    if (!got_done) check("done_timeout", 64'd0, 64'd1);

    // start coinciding with the done cycle must be ignored
    start_s[idx] = extra_starts;
    @(negedge clk);
    start_s[idx] = 1'b0;
    check("post_done_busy",  64'(busy_s[idx]),  64'd0);
    check("post_done_done",  64'(done_s[idx]),  64'd0);
    check("post_done_valid", 64'(valid_s[idx]), 64'd0);
    @(negedge clk);
    check("idle_stays_idle", 64'(valid_s[idx]), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame, no backpressure
    run_frame(0, 16, 1024, 64, 22'd0, 100, 1088, 0, 1'b0);
    // Random backpressure, same address sequence
    run_frame(0, 16, 1024, 64, 22'd0, 50, 0, 0, 1'b0);
    // Spurious starts mid-frame and at done
    run_frame(0, 16, 1024, 64, 22'd0, 100, 1088, 0, 1'b1);
    // Reset during tile 3, ch 7 (cycle 1 + 3*17 + 7), then clean restart
    run_frame(0, 16, 1024, 64, 22'd0, 100, 0, 59, 1'b0);
    run_frame(0, 16, 1024, 64, 22'd0, 100, 1088, 0, 1'b0);
    // Small geometry with nonzero start address
    run_frame(1, 4, 16, 4, 22'd100, 100, 20, 0, 1'b0);
    run_frame(1, 4, 16, 4, 22'd100, 40, 0, 0, 1'b0);
    // Address wrap modulo 2^22
    run_frame(2, 16, 1024, 64, WRAP_START, 100, 1088, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
